// File: rtl/ws2811_receiver_if.sv
// Bus between the WS2811 line decoder and its downstream consumers.
// The master side is the decoder, which takes the serial line in and drives pixel and frame status out.
interface ws2811_receiver_if #(
    parameter int COUNT_WIDTH = 16
) ();
    logic                   rxIN;
    logic [23:0]            dataOUT;
    logic                   dataValidOUT;
    logic                   frameEndOUT;
    logic                   errorOUT;
    logic [COUNT_WIDTH-1:0] pixelCountOUT;
    logic                   armedOUT;

    modport master (
        input  rxIN,
        output dataOUT,
        output dataValidOUT,
        output frameEndOUT,
        output errorOUT,
        output pixelCountOUT,
        output armedOUT
    );

    modport slave (
        output rxIN,
        input  dataOUT,
        input  dataValidOUT,
        input  frameEndOUT,
        input  errorOUT,
        input  pixelCountOUT,
        input  armedOUT
    );
endinterface

// File: rtl/ws2811_receiver.sv
// WS2811/WS2812 single-wire NRZ decoder: measures high/low times of the synchronised line and
// recovers 24-bit pixels (MSB first), frame-latch gaps and protocol errors.
module ws2811_receiver #(
    parameter int CLOCK_SPEED  = 50_000_000,
    parameter int THRESHOLD_NS = 475,
    parameter int MIN_HIGH_NS  = 100,
    parameter int MAX_HIGH_NS  = 2000,
    parameter int RESET_NS     = 50_000,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic              clkIN,
    input  logic              nResetIN,
    ws2811_receiver_if.master bus
);
    localparam int CYC_PER_US = CLOCK_SPEED / 1_000_000;
    localparam int C_THR      = CYC_PER_US * THRESHOLD_NS / 1000;
    localparam int C_MIN      = CYC_PER_US * MIN_HIGH_NS / 1000;
    localparam int C_MAX      = CYC_PER_US * MAX_HIGH_NS / 1000;
    localparam int C_RST      = CYC_PER_US * RESET_NS / 1000;

    localparam int HIGH_W = $clog2(C_MAX + 1);
    localparam int LOW_W  = $clog2(C_RST + 1);

    localparam logic [HIGH_W-1:0] C_THR_H    = HIGH_W'(C_THR);
    localparam logic [HIGH_W-1:0] C_MIN_H    = HIGH_W'(C_MIN);
    localparam logic [HIGH_W-1:0] C_MAX_M1_H = HIGH_W'(C_MAX - 1);
    localparam logic [LOW_W-1:0]  C_RST_L    = LOW_W'(C_RST);
    localparam logic [LOW_W-1:0]  C_RST_M1_L = LOW_W'(C_RST - 1);
    localparam logic [4:0]        LAST_BIT   = 5'd23;

    typedef enum logic [1:0] {
        ST_WAIT_RESET,
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc_pix(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0/p1: two-flop synchroniser for the asynchronous serial line
    logic r_rx_p0;
    logic r_rx_p1;
    logic w_s;

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_rx_p0 <= 1'b0;
            r_rx_p1 <= 1'b0;
        end else begin
            r_rx_p0 <= bus.rxIN;
            r_rx_p1 <= r_rx_p0;
        end
    end

    assign w_s = r_rx_p1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LOW_W-1:0]       r_low_cnt;
    logic [LOW_W-1:0]       w_low_nxt;
    logic [HIGH_W-1:0]      r_high_cnt;
    logic [HIGH_W-1:0]      w_high_nxt;
    logic [4:0]             r_bit_cnt;
    logic [4:0]             w_bit_nxt;
    logic [23:0]            r_shift;
    logic [23:0]            w_shift_nxt;
    logic                   r_from_idle;
    logic                   w_from_idle_nxt;
    logic [23:0]            r_data;
    logic [23:0]            w_data_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_frame_end;
    logic                   w_frame_end_nxt;
    logic                   r_error;
    logic                   w_error_nxt;
    logic [COUNT_WIDTH-1:0] r_pix_cnt;
    logic [COUNT_WIDTH-1:0] w_pix_nxt;

    logic                   w_bit;
    logic [23:0]            w_shifted;
    logic [COUNT_WIDTH-1:0] w_pix_base;

    assign w_bit      = (r_high_cnt >= C_THR_H);
    assign w_shifted  = {r_shift[22:0], w_bit};
    // The first accepted bit after a frame boundary restarts the pixel count
    assign w_pix_base = r_from_idle ? '0 : r_pix_cnt;

    // Stage p2: line-timing decoder
    always_comb begin
        w_state_nxt     = r_state;
        w_low_nxt       = r_low_cnt;
        w_high_nxt      = r_high_cnt;
        w_bit_nxt       = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_from_idle_nxt = r_from_idle;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_end_nxt = 1'b0;
        w_error_nxt     = 1'b0;
        w_pix_nxt       = r_pix_cnt;

        unique case (r_state)
            ST_WAIT_RESET: begin
                if (w_s) begin
                    w_low_nxt = '0;
                end else if (r_low_cnt == C_RST_M1_L) begin
                    w_state_nxt = ST_IDLE;
                    w_low_nxt   = '0;
                end else begin
                    w_low_nxt = r_low_cnt + 1'b1;
                end
            end

            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt     = ST_HIGH;
                    w_high_nxt      = HIGH_W'(1);
                    w_from_idle_nxt = 1'b1;
                end else if (r_low_cnt != C_RST_L) begin
                    w_low_nxt = r_low_cnt + 1'b1;
                end
            end

            ST_LOW: begin
                if (w_s) begin
                    w_state_nxt     = ST_HIGH;
                    w_high_nxt      = HIGH_W'(1);
                    w_from_idle_nxt = 1'b0;
                end else if (r_low_cnt == C_RST_M1_L) begin
                    w_state_nxt     = ST_IDLE;
                    w_low_nxt       = '0;
                    w_frame_end_nxt = 1'b1;
                    if (r_bit_cnt != 5'd0) begin
                        w_error_nxt = 1'b1;
                        w_bit_nxt   = 5'd0;
                        w_shift_nxt = '0;
                    end
                end else begin
                    w_low_nxt = r_low_cnt + 1'b1;
                end
            end

            ST_HIGH: begin
                if (w_s) begin
                    // A stuck-high line drops sync until a full reset gap is seen again
                    if (r_high_cnt == C_MAX_M1_H) begin
                        w_state_nxt = ST_WAIT_RESET;
                        w_error_nxt = 1'b1;
                        w_low_nxt   = '0;
                        w_high_nxt  = '0;
                        w_bit_nxt   = 5'd0;
                        w_shift_nxt = '0;
                    end else begin
                        w_high_nxt = r_high_cnt + 1'b1;
                    end
                end else if (r_high_cnt < C_MIN_H) begin
                    // Glitch: resume the interrupted low period with its count intact
                    w_state_nxt = r_from_idle ? ST_IDLE : ST_LOW;
                    w_high_nxt  = '0;
                end else begin
                    w_state_nxt     = ST_LOW;
                    w_low_nxt       = LOW_W'(1);
                    w_high_nxt      = '0;
                    w_shift_nxt     = w_shifted;
                    w_from_idle_nxt = 1'b0;
                    w_pix_nxt       = w_pix_base;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_data_nxt  = w_shifted;
                        w_valid_nxt = 1'b1;
                        w_bit_nxt   = 5'd0;
                        w_pix_nxt   = sat_inc_pix(w_pix_base);
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_WAIT_RESET;
            end
        endcase
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_state     <= ST_WAIT_RESET;
            r_low_cnt   <= '0;
            r_high_cnt  <= '0;
            r_bit_cnt   <= 5'd0;
            r_shift     <= '0;
            r_from_idle <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_error     <= 1'b0;
            r_pix_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_low_cnt   <= w_low_nxt;
            r_high_cnt  <= w_high_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_from_idle <= w_from_idle_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_end <= w_frame_end_nxt;
            r_error     <= w_error_nxt;
            r_pix_cnt   <= w_pix_nxt;
        end
    end

    assign bus.dataOUT       = r_data;
    assign bus.dataValidOUT  = r_valid;
    assign bus.frameEndOUT   = r_frame_end;
    assign bus.errorOUT      = r_error;
    assign bus.pixelCountOUT = r_pix_cnt;
    assign bus.armedOUT      = (r_state != ST_WAIT_RESET);
endmodule
